// File: rtl/snapshot_hs_reg.sv
// snapshot_hs_reg: atomic multi-partition snapshot register with handshakes.
// Optional stale-sequence timeout: define SNAPSHOT_TIMEOUT_EN.
module snapshot_hs_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_WIDTH      = 36,
  parameter int TRIG_HIGH      = 0,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int PARTITION_CNT =
    (REG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_rst,
  input  logic [PARTITION_CNT-1:0] snap_rd_en,
  input  logic [PARTITION_CNT-1:0] snap_wr_en,
  input  logic [DATA_WIDTH-1:0]    snap_wr_data,
  output logic [DATA_WIDTH-1:0]    snap_rd_data,
  output logic                     snap_ack,
  output logic                     seq_err,
  output logic                     reg_rd_en,
  input  logic                     reg_rd_ack,
  input  logic [REG_WIDTH-1:0]     reg_rd_data,
  output logic                     reg_wr_en,
  input  logic                     reg_wr_ack,
  output logic [REG_WIDTH-1:0]     reg_wr_data
);

  localparam int BW = PARTITION_CNT * DATA_WIDTH;
  localparam int TP = (TRIG_HIGH != 0) ? PARTITION_CNT - 1 : 0;
  localparam logic [BW-1:0] MASK = {BW{1'b1}} >> (BW - REG_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_HOLD,
    WR_COLLECT,
    WR_WAIT
  } state_t;

  state_t                  state_q, state_n;
  logic [BW-1:0]           buf_q, buf_n;
  logic [DATA_WIDTH-1:0]   rd_data_n;
  logic                    ack_n, err_n;
  logic                    rd_en_n, wr_en_n;
  logic [REG_WIDTH-1:0]    wr_data_n;
  logic [BW-1:0]           rd_ext;
  logic [BW-1:0]           merged;
  logic [PARTITION_CNT-1:0] sel;
  logic                    rd_any, wr_any, req, bad;
  int                      idx;

`ifdef SNAPSHOT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_n;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  function automatic int part_idx(
    input logic [PARTITION_CNT-1:0] v
  );
    part_idx = 0;
    for (int i = 0; i < PARTITION_CNT; i++) begin
      if (v[i]) part_idx = i;
    end
  endfunction

  // Decode the upstream request and build the padded data views.
  always_comb begin
    rd_any = |snap_rd_en;
    wr_any = |snap_wr_en;
    req    = rd_any | wr_any;
    sel    = rd_any ? snap_rd_en : snap_wr_en;
    bad    = req && ((rd_any && wr_any) || !$onehot(sel));
    idx    = part_idx(sel);
    rd_ext = '0;
    rd_ext[REG_WIDTH-1:0] = reg_rd_data;
    merged = buf_q;
    merged[idx*DATA_WIDTH +: DATA_WIDTH] = snap_wr_data;
    merged = merged & MASK;
  end

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_n   = state_q;
    buf_n     = buf_q;
    rd_data_n = snap_rd_data;
    ack_n     = 1'b0;
    err_n     = 1'b0;
    rd_en_n   = reg_rd_en;
    wr_en_n   = reg_wr_en;
    wr_data_n = reg_wr_data;
`ifdef SNAPSHOT_TIMEOUT_EN
    cnt_n     = '0;
`endif
    if (soft_rst) begin
      state_n   = IDLE;
      buf_n     = '0;
      rd_data_n = '0;
      rd_en_n   = 1'b0;
      wr_en_n   = 1'b0;
      wr_data_n = '0;
    end else begin
      unique case (state_q)
        RD_WAIT: begin
          if (req) err_n = 1'b1;
          if (reg_rd_ack) begin
            buf_n     = rd_ext;
            rd_data_n = rd_ext[TP*DATA_WIDTH +: DATA_WIDTH];
            rd_en_n   = 1'b0;
            ack_n     = 1'b1;
            state_n   = (PARTITION_CNT == 1) ? IDLE : RD_HOLD;
          end
        end
        WR_WAIT: begin
          if (req) err_n = 1'b1;
          if (reg_wr_ack) begin
            wr_en_n = 1'b0;
            ack_n   = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          if (bad) begin
            err_n = 1'b1;
          end else if (rd_any) begin
            if (state_q == WR_COLLECT) err_n = 1'b1;
            if (idx == TP) begin
              state_n = RD_WAIT;
              rd_en_n = 1'b1;
            end else begin
              rd_data_n = buf_q[idx*DATA_WIDTH +: DATA_WIDTH];
              ack_n     = 1'b1;
            end
          end else if (wr_any) begin
            buf_n = merged;
            if (idx == TP) begin
              wr_data_n = merged[REG_WIDTH-1:0];
              wr_en_n   = 1'b1;
              state_n   = WR_WAIT;
            end else begin
              ack_n   = 1'b1;
              state_n = WR_COLLECT;
            end
          end
`ifdef SNAPSHOT_TIMEOUT_EN
          if (!req && state_q != IDLE) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
              state_n = IDLE;
              err_n   = 1'b1;
            end else begin
              cnt_n = cnt_q + 1'b1;
            end
          end
`endif
        end
      endcase
    end
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      snap_rd_data <= '0;
      snap_ack     <= 1'b0;
      seq_err      <= 1'b0;
      reg_rd_en    <= 1'b0;
      reg_wr_en    <= 1'b0;
      reg_wr_data  <= '0;
    end else begin
      state_q      <= state_n;
      buf_q        <= buf_n;
      snap_rd_data <= rd_data_n;
      snap_ack     <= ack_n;
      seq_err      <= err_n;
      reg_rd_en    <= rd_en_n;
      reg_wr_en    <= wr_en_n;
      reg_wr_data  <= wr_data_n;
    end
  end

`ifdef SNAPSHOT_TIMEOUT_EN
  // Idle-cycle counter for open sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_n;
  end
`endif

endmodule
